// File: rtl/bus_slave_response_mux_if.sv
// Bus-side signal bundle for the slave response mux: master request,
// per-slave chip selects/data/ready, and the single response back to the master.
interface bus_slave_response_mux_if #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32
);
  logic                             i_data_valid;
  logic [NUM_SLAVES-1:0]            i_cs;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_slave_rdata;
  logic [NUM_SLAVES-1:0]            i_slave_ready;
  logic [DATA_WIDTH-1:0]            o_rdata;
  logic                             o_ready;
  logic                             o_error;
  logic                             o_busy;

  modport master (
    output i_data_valid, i_cs, i_slave_rdata, i_slave_ready,
    input  o_rdata, o_ready, o_error, o_busy
  );

  modport slave (
    input  i_data_valid, i_cs, i_slave_rdata, i_slave_ready,
    output o_rdata, o_ready, o_error, o_busy
  );
endinterface

// File: rtl/bus_slave_response_mux.sv
// Latches the chip-selected slave for a bus transfer, waits for its ready and
// returns one registered response; unmapped or hung transfers end in an error.
module bus_slave_response_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  bus_slave_response_mux_if.slave bus
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [SEL_W-1:0]      r_sel;
  logic [SEL_W-1:0]      w_sel_next;
  logic [TMR_W-1:0]      r_timer;
  logic [TMR_W-1:0]      w_timer_next;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_rdata_next;
  logic                  r_error;
  logic                  w_error_next;
  logic                  r_ready;
  logic                  r_busy;
  logic                  w_sel_ready;
  logic [DATA_WIDTH-1:0] w_sel_rdata;
  logic                  w_timeout;

  // Overlapping chip selects resolve to the lowest-numbered slave.
  function automatic logic [SEL_W-1:0] f_lowest_cs(input logic [NUM_SLAVES-1:0] cs);
    f_lowest_cs = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (cs[k]) f_lowest_cs = SEL_W'(k);
    end
  endfunction

  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (r_sel == SEL_W'(k)) begin
        w_sel_ready = bus.i_slave_ready[k];
        w_sel_rdata = bus.i_slave_rdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_timeout = (r_timer == TMR_W'(TIMEOUT - 1));

  always_comb begin
    w_next       = r_state;
    w_sel_next   = r_sel;
    w_timer_next = r_timer;
    w_rdata_next = r_rdata;
    w_error_next = r_error;
    case (r_state)
      S_IDLE: begin
        if (bus.i_data_valid) begin
          if (|bus.i_cs) begin
            w_sel_next   = f_lowest_cs(bus.i_cs);
            w_timer_next = '0;
            w_next       = S_WAIT;
          end else begin
            w_rdata_next = '0;
            w_error_next = 1'b1;
            w_next       = S_RESP;
          end
        end
      end
      S_WAIT: begin
        // A ready arriving on the timeout cycle still counts as a good response.
        if (w_sel_ready) begin
          w_rdata_next = w_sel_rdata;
          w_error_next = 1'b0;
          w_next       = S_RESP;
        end else if (w_timeout) begin
          w_rdata_next = '0;
          w_error_next = 1'b1;
          w_next       = S_RESP;
        end else begin
          w_timer_next = r_timer + TMR_W'(1);
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_timer <= '0;
      r_rdata <= '0;
      r_error <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sel   <= w_sel_next;
      r_timer <= w_timer_next;
      r_rdata <= w_rdata_next;
      r_error <= w_error_next;
      r_ready <= (w_next == S_RESP);
      r_busy  <= (w_next != S_IDLE);
    end
  end

  assign bus.o_rdata = r_rdata;
  assign bus.o_error = r_error;
  assign bus.o_ready = r_ready;
  assign bus.o_busy  = r_busy;

endmodule

// File: tb/tb_bus_slave_response_mux.sv
// Randomized bench for bus_slave_response_mux with a per-cycle expected-output
// timeline built from whole-transaction rules, plus directed literal checks.
module tb_bus_slave_response_mux;
  localparam int NS   = 4;
  localparam int DW   = 32;
  localparam int TO   = 16;
  localparam int MAXC = 8000;

  logic clk = 1'b0;
  logic n_rst;

  bus_slave_response_mux_if #(.NUM_SLAVES(NS), .DATA_WIDTH(DW)) bif ();

  bus_slave_response_mux #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic          exp_ready [MAXC];
  logic          exp_busy  [MAXC];
  logic          exp_error [MAXC];
  logic [DW-1:0] exp_rdata [MAXC];

  logic [NS-1:0] rpat [TO+1];
  logic [DW-1:0] dpat [TO+1][NS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc >= MAXC) begin
        $display("FAIL cycle_budget: cycle %0d reached limit %0d", cyc, MAXC);
        $fatal(1, "cycle budget exhausted");
      end
      check($sformatf("o_ready@%0d", cyc), bif.o_ready, exp_ready[cyc]);
      check($sformatf("o_busy@%0d",  cyc), bif.o_busy,  exp_busy[cyc]);
      check($sformatf("o_error@%0d", cyc), bif.o_error, exp_error[cyc]);
      check($sformatf("o_rdata@%0d", cyc), bif.o_rdata, exp_rdata[cyc]);
    end
  end

  function automatic int lowest(input logic [NS-1:0] cs);
    for (int k = 0; k < NS; k++) if (cs[k]) return k;
    return -1;
  endfunction

  task automatic clear_model(input int from);
    for (int c = from; c < MAXC; c++) begin
      exp_ready[c] = 1'b0;
      exp_busy[c]  = 1'b0;
      exp_error[c] = 1'b0;
      exp_rdata[c] = '0;
    end
  endtask

  task automatic clear_pat();
    for (int k = 1; k <= TO; k++) begin
      rpat[k] = '0;
      for (int s = 0; s < NS; s++) dpat[k][s] = $urandom;
    end
  endtask

  task automatic rand_rdata();
    for (int s = 0; s < NS; s++) bif.i_slave_rdata[s*DW +: DW] = $urandom;
  endtask

  task automatic idle_cycle();
    bif.i_data_valid  = 1'b0;
    bif.i_cs          = NS'($urandom);
    bif.i_slave_ready = NS'($urandom);
    rand_rdata();
    @(posedge clk); #1;
  endtask

  // Called at #1 into an IDLE cycle; predicts the whole transaction, then drives it.
  task automatic run_txn(input logic [NS-1:0] cs, output int lat,
                         output logic obs_ready, output logic obs_error,
                         output logic [DW-1:0] obs_rdata);
    int c0, sel, hit, resp;
    logic err;
    logic [DW-1:0] d;
    c0  = cyc;
    sel = lowest(cs);
    hit = 0;
    if (sel < 0) begin
      resp = c0 + 1; err = 1'b1; d = '0;
    end else begin
      for (int k = 1; k <= TO; k++) if (hit == 0 && rpat[k][sel]) hit = k;
      if (hit != 0) begin
        resp = c0 + hit + 1; err = 1'b0; d = dpat[hit][sel];
      end else begin
        resp = c0 + TO + 1; err = 1'b1; d = '0;
      end
    end
    lat = resp - c0;
    if (resp + 2 >= MAXC) begin
      $display("FAIL model_budget: response cycle %0d beyond limit %0d", resp, MAXC);
      $fatal(1, "model budget exhausted");
    end
    for (int c = c0 + 1; c <= resp; c++) exp_busy[c] = 1'b1;
    exp_ready[resp] = 1'b1;
    for (int c = resp; c < MAXC; c++) begin
      exp_rdata[c] = d;
      exp_error[c] = err;
    end

    bif.i_data_valid  = 1'b1;
    bif.i_cs          = cs;
    bif.i_slave_ready = NS'($urandom);
    rand_rdata();
    for (int k = 1; k < lat; k++) begin
      @(posedge clk); #1;
      bif.i_data_valid  = 1'($urandom % 2);
      bif.i_cs          = NS'($urandom);
      bif.i_slave_ready = rpat[k];
      for (int s = 0; s < NS; s++) bif.i_slave_rdata[s*DW +: DW] = dpat[k][s];
    end
    @(posedge clk); #1;
    obs_ready = bif.o_ready;
    obs_error = bif.o_error;
    obs_rdata = bif.o_rdata;
    bif.i_data_valid  = 1'($urandom % 2);
    bif.i_cs          = NS'($urandom);
    bif.i_slave_ready = NS'($urandom);
    rand_rdata();
    @(posedge clk); #1;
    bif.i_data_valid = 1'b0;
  endtask

  initial begin
    #((MAXC + 100) * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat;
    logic          r, e;
    logic [DW-1:0] d;
    logic [NS-1:0] cs;
    int            sel, mode, kk;

    clear_model(0);
    n_rst             = 1'b0;
    bif.i_data_valid  = 1'b0;
    bif.i_cs          = '0;
    bif.i_slave_ready = '0;
    bif.i_slave_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",  bif.o_busy,  1'b0);
    check("reset_ready", bif.o_ready, 1'b0);
    check("reset_error", bif.o_error, 1'b0);
    check("reset_rdata", bif.o_rdata, 32'h0);
    n_rst  = 1'b1;
    chk_en = 1'b1;
    idle_cycle();
    idle_cycle();

    // Basic read from slave 1, ready three cycles after the request.
    clear_pat();
    rpat[3]    = 4'b0010;
    dpat[3][1] = 32'hDEADBEEF;
    run_txn(4'b0010, lat, r, e, d);
    check("basic_lat",   lat, 4);
    check("basic_ready", r, 1'b1);
    check("basic_error", e, 1'b0);
    check("basic_rdata", d, 32'hDEADBEEF);
    idle_cycle();

    // Unmapped request.
    clear_pat();
    run_txn(4'b0000, lat, r, e, d);
    check("unmapped_lat",   lat, 1);
    check("unmapped_ready", r, 1'b1);
    check("unmapped_error", e, 1'b1);
    check("unmapped_rdata", d, 32'h0);
    idle_cycle();

    // Slave 3 never answers.
    clear_pat();
    run_txn(4'b1000, lat, r, e, d);
    check("timeout_lat",   lat, 17);
    check("timeout_ready", r, 1'b1);
    check("timeout_error", e, 1'b1);
    check("timeout_rdata", d, 32'h0);

    // Ready lands on the last allowed cycle.
    clear_pat();
    rpat[TO]    = 4'b1000;
    dpat[TO][3] = 32'h12345678;
    run_txn(4'b1000, lat, r, e, d);
    check("tie_lat",   lat, 17);
    check("tie_error", e, 1'b0);
    check("tie_rdata", d, 32'h12345678);
    idle_cycle();

    // Overlapping selects with noise from an unselected slave.
    clear_pat();
    rpat[1]    = 4'b0001;
    rpat[2]    = 4'b0001;
    rpat[3]    = 4'b0110;
    dpat[3][1] = 32'hA1A1A1A1;
    dpat[3][2] = 32'hB2B2B2B2;
    run_txn(4'b0110, lat, r, e, d);
    check("overlap_lat",   lat, 4);
    check("overlap_error", e, 1'b0);
    check("overlap_rdata", d, 32'hA1A1A1A1);
    idle_cycle();

    // Reset in the middle of a wait on slave 2.
    chk_en            = 1'b0;
    bif.i_data_valid  = 1'b1;
    bif.i_cs          = 4'b0100;
    bif.i_slave_ready = 4'b0000;
    repeat (3) begin
      @(posedge clk); #1;
      bif.i_slave_ready = NS'($urandom) & 4'b1011;
      bif.i_data_valid  = 1'($urandom % 2);
    end
    check("midwait_busy", bif.o_busy, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_busy",  bif.o_busy,  1'b0);
    check("async_rst_ready", bif.o_ready, 1'b0);
    check("async_rst_error", bif.o_error, 1'b0);
    check("async_rst_rdata", bif.o_rdata, 32'h0);
    clear_model(cyc);
    chk_en = 1'b1;
    @(posedge clk); #1;
    bif.i_data_valid = 1'b0;
    n_rst            = 1'b1;
    repeat (6) idle_cycle();

    // Randomized transactions with back-to-back and gapped issue.
    for (int t = 0; t < 150; t++) begin
      cs   = (($urandom % 8) == 0) ? '0 : NS'($urandom);
      sel  = lowest(cs);
      mode = $urandom % 4;
      clear_pat();
      for (int k = 1; k <= TO; k++) begin
        rpat[k] = NS'($urandom);
        if (sel >= 0) rpat[k][sel] = 1'b0;
      end
      if (sel >= 0) begin
        case (mode)
          1: for (int k = 1; k <= TO; k++) if (($urandom % 4) == 0) rpat[k][sel] = 1'b1;
          2: begin kk = $urandom_range(1, TO); rpat[kk][sel] = 1'b1; end
          3: begin kk = (($urandom % 2) == 0) ? 1 : TO; rpat[kk][sel] = 1'b1; end
          default: ;
        endcase
      end
      run_txn(cs, lat, r, e, d);
      repeat ($urandom % 3) idle_cycle();
    end

    repeat (3) idle_cycle();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
